// File: rtl/capture_ctrl.sv
// Capture controller: ring-buffer sample capture into LUT-RAM, programmable post-trigger
// length, then newest-first readback streamed over a valid/ready handshake.
module capture_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [DEPTH:0]   cfg_delay_i,
  input  logic [DEPTH:0]   cfg_read_i,
  input  logic             smpl_valid_i,
  input  logic [WIDTH-1:0] smpl_i,
  input  logic             trg_i,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [DEPTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_d_o,
  input  logic [WIDTH-1:0] mem_d_i,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int N = 2 ** DEPTH;
  localparam logic [DEPTH:0] N_CNT = (DEPTH+1)'(N);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    RD_REQ,
    RD_WAIT,
    SEND
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]     dly_cnt_q, dly_cnt_d;
  logic [DEPTH:0]     rd_cnt_q, rd_cnt_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               done_q, done_d;
  logic               wr_fire;
  logic               enter_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dly_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dly_cnt_q  <= dly_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  // An abort in the same cycle as a sample suppresses the write so wr_ptr stays consistent.
  assign wr_fire = ((state_q == ARMED) || (state_q == POST)) && smpl_valid_i && !abort_i;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dly_cnt_d  = dly_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    enter_rd   = 1'b0;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_d_o    = '0;

    if (wr_fire) begin
      mem_en_o   = 1'b1;
      mem_we_o   = 1'b1;
      mem_addr_o = wr_ptr_q;
      mem_d_o    = smpl_i;
      wr_ptr_d   = wr_ptr_q + DEPTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d   = ARMED;
          dly_cnt_d = cfg_delay_i;
          rd_cnt_d  = (cfg_read_i > N_CNT) ? N_CNT : cfg_read_i;
        end
      end
      ARMED: begin
        if (wr_fire && trg_i) begin
          if (dly_cnt_q == '0) begin
            enter_rd = 1'b1;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (wr_fire) begin
          dly_cnt_d = dly_cnt_q - (DEPTH+1)'(1);
          if (dly_cnt_q == (DEPTH+1)'(1)) begin
            enter_rd = 1'b1;
          end
        end
      end
      RD_REQ: begin
        mem_en_o   = 1'b1;
        mem_addr_o = rd_ptr_q;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        tx_data_d  = mem_d_i;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          rd_cnt_d   = rd_cnt_q - (DEPTH+1)'(1);
          rd_ptr_d   = rd_ptr_q - DEPTH'(1);
          if (rd_cnt_q == (DEPTH+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The last write lands at wr_ptr_q, which is therefore the newest sample.
    if (enter_rd) begin
      rd_ptr_d = wr_ptr_q;
      if (rd_cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RD_REQ;
      end
    end

    if (abort_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: ring-buffer reference model plus a LUT-RAM stand-in with
// one-cycle read latency, driven with directed and randomized capture/readout runs.
module tb_capture_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int N     = 2 ** DEPTH;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             arm_i, abort_i;
  logic [DEPTH:0]   cfg_delay_i, cfg_read_i;
  logic             smpl_valid_i, trg_i;
  logic [WIDTH-1:0] smpl_i;
  logic             mem_en_o, mem_we_o;
  logic [DEPTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_d_o;
  logic [WIDTH-1:0] mem_d_i;
  logic             tx_valid_o, tx_ready_i;
  logic [WIDTH-1:0] tx_data_o;
  logic             busy_o, done_o;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] ram     [N];
  logic [WIDTH-1:0] ref_ram [N];
  int               ref_wp;

  capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .cfg_delay_i  (cfg_delay_i),
    .cfg_read_i   (cfg_read_i),
    .smpl_valid_i (smpl_valid_i),
    .smpl_i       (smpl_i),
    .trg_i        (trg_i),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_d_o      (mem_d_o),
    .mem_d_i      (mem_d_i),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_d_o;
      else          mem_d_i <= ram[mem_addr_o];
    end
  end

  task automatic check_all_zero(input string name);
    checks++;
    if ({mem_en_o, mem_we_o, tx_valid_o, busy_o, done_o} !== 5'b0 ||
        mem_addr_o !== '0 || mem_d_o !== '0 || tx_data_o !== '0) begin
      errors++;
      $display("FAIL %s: en=%b we=%b addr=%0h d=%0h txv=%b txd=%0h busy=%b done=%b, required all 0",
               name, mem_en_o, mem_we_o, mem_addr_o, mem_d_o, tx_valid_o, tx_data_o, busy_o, done_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; arm_i = 0; abort_i = 0; cfg_delay_i = '0; cfg_read_i = '0;
    smpl_valid_i = 0; trg_i = 0; smpl_i = '0; tx_ready_i = 0; mem_d_i = '0;
    ref_wp = 0;
    for (int i = 0; i < N; i++) begin
      ram[i]     = $urandom;
      ref_ram[i] = ram[i];
    end
    #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset_release");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    arm_i = 1; cfg_delay_i = 5'd8; cfg_read_i = 5'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      arm_i = 0; smpl_valid_i = 1; smpl_i = 32'hA000 + i; trg_i = (i == 2);
      ref_ram[ref_wp] = smpl_i;
      ref_wp = (ref_wp + 1) % N;
    end
    @(negedge clk);
    smpl_valid_i = 1; smpl_i = 32'hBEEF; trg_i = 0;
    #1;
    checks++;
    if (mem_we_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL post_write_before_reset: we=%b busy=%b, required 1 1", mem_we_o, busy_o);
    end
    #1 rst_i = 1'b1;
    #1;
    check_all_zero("async_reset_mid_post");
    ref_wp = 0;
    @(negedge clk);
    rst_i = 0; smpl_valid_i = 0;
  endtask

  task automatic run_capture(input string name, input int dly, input int rd, input bit directed,
                             input int trg_at, input int ready_low, input int abort_word,
                             input bit rnd_ready);
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] dat;
    int phase, rem, nvalid, idx, wait_cnt, last_hs, n;
    bit finished, aborted, v, t, r, capt;
    exp_q = {}; phase = 1; rem = dly; nvalid = 0; idx = 0; wait_cnt = 0; last_hs = -1;
    finished = 0; aborted = 0;

    @(negedge clk);
    arm_i = 1; abort_i = 0; tx_ready_i = 0;
    cfg_delay_i = (DEPTH+1)'(dly); cfg_read_i = (DEPTH+1)'(rd);
    smpl_valid_i = !directed; trg_i = !directed; smpl_i = $urandom;
    #1;
    checks++;
    if (mem_we_o !== 1'b0 || mem_en_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_write: en=%b we=%b, required 0 0", name, mem_en_o, mem_we_o);
    end

    for (int cyc = 0; cyc < 3000 && !finished && !aborted; cyc++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        checks++;
        if (phase != 3 || idx != exp_q.size() || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s done: words=%0d busy=%b phase=%0d, required words=%0d busy=0 phase=3",
                   name, idx, busy_o, phase, exp_q.size());
        end
        finished = 1;
        arm_i = 0; smpl_valid_i = 0; trg_i = 0; tx_ready_i = 0;
        break;
      end
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %b, required 1 (cycle %0d)", name, busy_o, cyc);
      end
      abort_i = 0;
      if (tx_valid_o === 1'b1) begin
        checks++;
        if (idx >= exp_q.size()) begin
          errors++;
          $display("FAIL %s extra_word: data=%0h, required no tx_valid (%0d words expected)",
                   name, tx_data_o, exp_q.size());
        end else if (tx_data_o !== exp_q[idx]) begin
          errors++;
          $display("FAIL %s tx_data[%0d]: got %0h, required %0h", name, idx, tx_data_o, exp_q[idx]);
        end
        if (rnd_ready) r = 1'($urandom_range(0, 1));
        else if (wait_cnt < ready_low) begin r = 0; wait_cnt++; end
        else r = 1;
        if (abort_word >= 0 && idx == abort_word) begin
          abort_i = 1; aborted = 1; r = 1;
        end
        tx_ready_i = r;
        if (r && !aborted) begin
          if (!rnd_ready && ready_low == 0 && last_hs >= 0) begin
            checks++;
            if (cyc - last_hs != 3) begin
              errors++;
              $display("FAIL %s throughput: %0d cycles between words, required 3", name, cyc - last_hs);
            end
          end
          last_hs = cyc; idx++; wait_cnt = 0;
        end
      end else begin
        tx_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end

      if (directed) begin
        v = 1; dat = WIDTH'(nvalid); t = (nvalid == trg_at);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        dat = $urandom;
        t = (v && phase == 1) ? (nvalid == trg_at) : 1'($urandom_range(0, 1));
      end
      arm_i = !directed && ($urandom_range(0, 15) == 0);
      if (arm_i) begin
        cfg_delay_i = (DEPTH+1)'($urandom);
        cfg_read_i  = (DEPTH+1)'($urandom);
      end
      smpl_valid_i = v; smpl_i = dat; trg_i = t;
      #1;
      capt = (phase == 1 || phase == 2) && v && !abort_i;
      checks++;
      if (mem_we_o !== capt) begin
        errors++;
        $display("FAIL %s mem_we: got %b, required %b (cycle %0d)", name, mem_we_o, capt, cyc);
      end
      if (capt) begin
        checks++;
        if (mem_en_o !== 1'b1 || mem_addr_o !== DEPTH'(ref_wp) || mem_d_o !== dat) begin
          errors++;
          $display("FAIL %s mem_write: en=%b addr=%0h d=%0h, required 1 %0h %0h",
                   name, mem_en_o, mem_addr_o, mem_d_o, ref_wp, dat);
        end
      end
      if (v) nvalid++;
      if (capt) begin
        ref_ram[ref_wp] = dat;
        ref_wp = (ref_wp + 1) % N;
        if (phase == 1) begin
          if (t) begin
            if (dly == 0) phase = 3;
            else begin phase = 2; rem = dly; end
          end
        end else begin
          rem--;
          if (rem == 0) phase = 3;
        end
        if (phase == 3) begin
          n = (rd > N) ? N : rd;
          for (int k = 0; k < n; k++) exp_q.push_back(ref_ram[(ref_wp - 1 - k + 2 * N) % N]);
        end
      end
    end

    if (aborted) begin
      @(negedge clk);
      abort_i = 0; arm_i = 0; smpl_valid_i = 0; trg_i = 0; tx_ready_i = 0;
      checks++;
      if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL %s abort: txv=%b busy=%b done=%b, required 0 0 0", name, tx_valid_o, busy_o, done_o);
      end
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || tx_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s abort_quiet: done=%b txv=%b, required 0 0", name, done_o, tx_valid_o);
        end
      end
    end else if (!finished) begin
      errors++;
      $display("FAIL %s timeout: words=%0d phase=%0d, required done", name, idx, phase);
    end else begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || tx_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: done=%b txv=%b, required 0 0", name, done_o, tx_valid_o);
      end
    end
  endtask

  task automatic test_basic();
    run_capture("basic", 4, 8, 1, 15, 0, -1, 0);
  endtask

  task automatic test_wrap();
    run_capture("wrap", 3, 16, 1, 19, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    run_capture("backpressure", 5, 10, 0, 7, 5, -1, 0);
  endtask

  task automatic test_edges();
    run_capture("delay0", 0, 4, 1, 3, 0, -1, 0);
    run_capture("read0", 2, 0, 0, 4, 0, -1, 0);
    run_capture("read_clamp", 1, 31, 0, 2, 0, -1, 0);
  endtask

  task automatic test_abort();
    run_capture("abort_send", 2, 8, 0, 5, 2, 2, 0);
    run_capture("rearm", 3, 6, 0, 4, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_capture("random", $urandom_range(0, 20), $urandom_range(0, 20), 0,
                  $urandom_range(0, 25), 0, -1, 1);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edges();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
